// File: rtl/pipemem_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | pipemem_pkg : shared types and constants for the MEM-stage ctrl  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package pipemem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0]  IO_NIBBLE = 4'hF;
  localparam logic [31:0] SW_ADDR   = 32'hF000_0000;
  localparam logic [31:0] LED_ADDR  = 32'hF000_0004;
  localparam logic [31:0] ERR_WORD  = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/pipemem_ctrl_sync2.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | sync2 : two-flop synchronizer, async active-low reset             |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module sync2 #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/pipemem_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | pipemem_ctrl : MEM-stage controller, zero-wait I/O + req/ack bus  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module pipemem_ctrl
  import pipemem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int LED_W   = 10,
  parameter int SW_W    = 10
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             mwmem,
  input  logic             mm2reg,
  input  logic [31:0]      malu,
  input  logic [31:0]      mb,
  output logic [31:0]      mmo,
  output logic             mem_stall,
  output logic             bus_req,
  output logic             bus_we,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  input  logic [31:0]      bus_rdata,
  input  logic             bus_ack,
  input  logic [SW_W-1:0]  sw_in,
  output logic [LED_W-1:0] led_out,
  output logic             bus_err
);

  localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        d_q, d_d;
  logic               we_q, we_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [SW_W-1:0]    sw_sync;
  logic               acc;
  logic               io;
  logic [31:0]        io_rdata;

  sync2 #(.W(SW_W)) u_sw_sync (
    .clock  (clock),
    .resetn (resetn),
    .d_i    (sw_in),
    .q_o    (sw_sync)
  );

  assign acc = mwmem | mm2reg;
  assign io  = (malu[31:28] == IO_NIBBLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      a_q     <= '0;
      d_q     <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      d_q     <= d_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    d_d     = d_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    led_d   = led_q;
    case (state_q)
      IDLE: begin
        if (acc && !io) begin
          state_d = BUSY;
          a_d     = malu;
          d_d     = mb;
          we_d    = mwmem;
          cnt_d   = '0;
        end
        if (mwmem && io && (malu == LED_ADDR)) begin
          led_d = mb[LED_W-1:0];
        end
      end
      BUSY: begin
        if (bus_ack) begin
          state_d = DONE;
          if (!we_q) rdata_d = bus_rdata;
        end else if (cnt_q == CNT_MAX) begin
          // Abandoned transaction: poison the load result and flag it.
          state_d = DONE;
          rdata_d = ERR_WORD;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io_rdata = '0;
    if (malu == SW_ADDR)       io_rdata = 32'(sw_sync);
    else if (malu == LED_ADDR) io_rdata = 32'(led_q);
  end

  always_comb begin
    mmo       = '0;
    mem_stall = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state_q)
      IDLE: begin
        mem_stall = acc && !io;
        if (mm2reg && io && !mwmem) mmo = io_rdata;
      end
      BUSY: begin
        mem_stall = 1'b1;
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = a_q;
        bus_wdata = d_q;
      end
      DONE:    mmo = rdata_q;
      default: ;
    endcase
  end

  assign led_out = led_q;
  assign bus_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipemem_ctrl.sv
`default_nettype none
// Scoreboard bench for pipemem_ctrl: load results are queued on issue and
// popped when the controller presents mmo.
module tb_pipemem_ctrl;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        mwmem = 1'b0;
  logic        mm2reg = 1'b0;
  logic [31:0] malu = '0;
  logic [31:0] mb = '0;
  logic [31:0] mmo;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic [9:0]  sw_in = '0;
  logic [9:0]  led_out;
  logic        bus_err;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  int          r_stall, r_busy;
  logic [31:0] r_mmo, r_addr, r_wdata;
  logic        r_we, r_held;

  pipemem_ctrl #(.TIMEOUT(4), .LED_W(10), .SW_W(10)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .mwmem     (mwmem),
    .mm2reg    (mm2reg),
    .malu      (malu),
    .mb        (mb),
    .mmo       (mmo),
    .mem_stall (mem_stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .bus_err   (bus_err)
  );

  always #5 clock = ~clock;

  // Drives one memory access and acts as the bus slave; ack_at==0 never acks.
  task automatic run_mem(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input int ack_at, input logic [31:0] rdata,
                         output int stall_n, output int busy_n, output logic [31:0] o_mmo,
                         output logic [31:0] o_addr, output logic [31:0] o_wdata,
                         output logic o_we, output logic held_ok);
    stall_n = 0; busy_n = 0; held_ok = 1'b1;
    o_mmo = '0; o_addr = '0; o_wdata = '0; o_we = 1'b0;
    mwmem = we; mm2reg = !we; malu = addr; mb = data;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (!mem_stall) begin
        o_mmo = mmo;
        break;
      end
      stall_n++;
      if (bus_req) begin
        busy_n++;
        if (busy_n == 1) begin
          o_addr = bus_addr; o_wdata = bus_wdata; o_we = bus_we;
        end else if (bus_addr !== o_addr || bus_wdata !== o_wdata || bus_we !== o_we) begin
          held_ok = 1'b0;
        end
        if (busy_n == ack_at) begin
          bus_ack = 1'b1; bus_rdata = rdata;
        end
      end
      @(posedge clock); #1;
      bus_ack = 1'b0; bus_rdata = '0;
    end
    @(posedge clock); #1;
    mwmem = 1'b0; mm2reg = 1'b0; malu = '0; mb = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (mmo !== 32'h0) begin errors++; $display("FAIL reset_mmo: got %h expected %h", mmo, 32'h0); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", mem_stall); end
    checks++; if ({bus_req, bus_we, bus_addr, bus_wdata} !== 66'h0) begin errors++;
      $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h expected all 0", bus_req, bus_we, bus_addr, bus_wdata); end
    checks++; if (led_out !== 10'h0) begin errors++; $display("FAIL reset_led: got %h expected 0", led_out); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus_err); end
    resetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_load();
    exp_q.push_back(32'h1234_5678);
    run_mem(1'b0, 32'h100, 32'h0, 1, 32'h1234_5678, r_stall, r_busy, r_mmo, r_addr, r_wdata, r_we, r_held);
    checks++; if (r_stall != 2) begin errors++; $display("FAIL load_stall: got %0d expected 2", r_stall); end
    checks++; if (r_addr !== 32'h100) begin errors++; $display("FAIL load_addr: got %h expected 00000100", r_addr); end
    checks++; if (r_we !== 1'b0) begin errors++; $display("FAIL load_we: got %b expected 0", r_we); end
    exp_v = exp_q.pop_front();
    checks++; if (r_mmo !== exp_v) begin errors++; $display("FAIL load_mmo: got %h expected %h", r_mmo, exp_v); end
  endtask

  task automatic test_store();
    exp_q.push_back(32'h1234_5678);  // rdata_q must survive a store
    run_mem(1'b1, 32'h200, 32'hCAFE_F00D, 3, 32'h0BAD_0BAD, r_stall, r_busy, r_mmo, r_addr, r_wdata, r_we, r_held);
    checks++; if (r_stall != 4) begin errors++; $display("FAIL store_stall: got %0d expected 4", r_stall); end
    checks++; if (r_busy != 3) begin errors++; $display("FAIL store_busy: got %0d expected 3", r_busy); end
    checks++; if (r_we !== 1'b1 || r_wdata !== 32'hCAFE_F00D || r_addr !== 32'h200 || !r_held) begin errors++;
      $display("FAIL store_bus: got we=%b wdata=%h addr=%h held=%b expected 1 cafef00d 00000200 1", r_we, r_wdata, r_addr, r_held); end
    exp_v = exp_q.pop_front();
    checks++; if (r_mmo !== exp_v) begin errors++; $display("FAIL store_rdata_kept: got %h expected %h", r_mmo, exp_v); end
  endtask

  task automatic test_io();
    mwmem = 1'b1; malu = 32'hF000_0004; mb = 32'h0000_03FF;
    @(negedge clock);
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL io_store_stall: got %b expected 0", mem_stall); end
    checks++; if (led_out !== 10'h0) begin errors++; $display("FAIL led_early: got %h expected 000", led_out); end
    @(posedge clock); #1;
    mwmem = 1'b0; mm2reg = 1'b1; mb = '0;
    exp_q.push_back(32'h0000_03FF);
    @(negedge clock);
    checks++; if (led_out !== 10'h3FF) begin errors++; $display("FAIL led_update: got %h expected 3ff", led_out); end
    checks++; if (mem_stall !== 1'b0 || bus_req !== 1'b0) begin errors++;
      $display("FAIL io_load_nostall: got stall=%b req=%b expected 0 0", mem_stall, bus_req); end
    exp_v = exp_q.pop_front();
    checks++; if (mmo !== exp_v) begin errors++; $display("FAIL io_led_read: got %h expected %h", mmo, exp_v); end
    @(posedge clock); #1;
    malu = 32'hF000_0008; exp_q.push_back(32'h0);
    @(negedge clock);
    exp_v = exp_q.pop_front();
    checks++; if (mmo !== exp_v) begin errors++; $display("FAIL io_other_read: got %h expected %h", mmo, exp_v); end
    @(posedge clock); #1;
    malu = 32'hF000_0000; sw_in = 10'h155;
    // Switch value must appear on exactly the second edge after the change.
    for (int e = 0; e < 3; e++) begin
      exp_q.push_back((e == 2) ? 32'h155 : 32'h0);
      @(negedge clock);
      exp_v = exp_q.pop_front();
      checks++; if (mmo !== exp_v) begin errors++; $display("FAIL sw_read_edge%0d: got %h expected %h", e, mmo, exp_v); end
      @(posedge clock); #1;
    end
    mwmem = 1'b1; mb = 32'h0000_0001; exp_q.push_back(32'h0);
    @(negedge clock);
    exp_v = exp_q.pop_front();
    checks++; if (mmo !== exp_v) begin errors++; $display("FAIL io_store_wins: got %h expected %h", mmo, exp_v); end
    @(posedge clock); #1;
    mwmem = 1'b0; mm2reg = 1'b0; malu = '0; mb = '0;
    @(negedge clock);
    checks++; if (led_out !== 10'h3FF) begin errors++; $display("FAIL led_hold: got %h expected 3ff", led_out); end
    @(posedge clock); #1;
  endtask

  task automatic test_timeout();
    exp_q.push_back(32'hDEAD_BEEF);
    run_mem(1'b0, 32'h300, 32'h0, 0, 32'h0, r_stall, r_busy, r_mmo, r_addr, r_wdata, r_we, r_held);
    checks++; if (r_stall != 5) begin errors++; $display("FAIL timeout_stall: got %0d expected 5", r_stall); end
    exp_v = exp_q.pop_front();
    checks++; if (r_mmo !== exp_v) begin errors++; $display("FAIL timeout_mmo: got %h expected %h", r_mmo, exp_v); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", bus_err); end
    exp_q.push_back(32'hA5A5_A5A5);
    run_mem(1'b0, 32'h400, 32'h0, 2, 32'hA5A5_A5A5, r_stall, r_busy, r_mmo, r_addr, r_wdata, r_we, r_held);
    checks++; if (r_stall != 3) begin errors++; $display("FAIL ack2_stall: got %0d expected 3", r_stall); end
    exp_v = exp_q.pop_front();
    checks++; if (r_mmo !== exp_v) begin errors++; $display("FAIL ack2_mmo: got %h expected %h", r_mmo, exp_v); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", bus_err); end
  endtask

  task automatic test_ack_idle();
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    repeat (2) begin
      @(negedge clock);
      checks++; if (mem_stall !== 1'b0 || bus_req !== 1'b0 || mmo !== 32'h0) begin errors++;
        $display("FAIL stray_ack: got stall=%b req=%b mmo=%h expected 0 0 0", mem_stall, bus_req, mmo); end
      @(posedge clock); #1;
    end
    bus_ack = 1'b0; bus_rdata = '0;
    exp_q.push_back(32'hA5A5_A5A5);
    run_mem(1'b1, 32'h440, 32'h7777_7777, 1, 32'h2222_2222, r_stall, r_busy, r_mmo, r_addr, r_wdata, r_we, r_held);
    checks++; if (r_stall != 2) begin errors++; $display("FAIL stray_store_stall: got %0d expected 2", r_stall); end
    exp_v = exp_q.pop_front();
    checks++; if (r_mmo !== exp_v) begin errors++; $display("FAIL stray_rdata_kept: got %h expected %h", r_mmo, exp_v); end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(32'h0102_0304);
    run_mem(1'b0, 32'h500, 32'h0, 1, 32'h0102_0304, r_stall, r_busy, r_mmo, r_addr, r_wdata, r_we, r_held);
    exp_v = exp_q.pop_front();
    checks++; if (r_stall != 2 || r_mmo !== exp_v) begin errors++;
      $display("FAIL b2b_first: got stall=%0d mmo=%h expected 2 %h", r_stall, r_mmo, exp_v); end
    exp_q.push_back(32'h0506_0708);
    run_mem(1'b0, 32'h504, 32'h0, 2, 32'h0506_0708, r_stall, r_busy, r_mmo, r_addr, r_wdata, r_we, r_held);
    exp_v = exp_q.pop_front();
    checks++; if (r_stall != 3 || r_mmo !== exp_v || r_addr !== 32'h504) begin errors++;
      $display("FAIL b2b_second: got stall=%0d mmo=%h addr=%h expected 3 %h 00000504", r_stall, r_mmo, r_addr, exp_v); end
  endtask

  task automatic test_reset_mid_busy();
    mm2reg = 1'b1; malu = 32'h600;
    @(posedge clock); #1;
    @(negedge clock);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL midbusy_req_before: got %b expected 1", bus_req); end
    #1;
    resetn = 1'b0; mm2reg = 1'b0; malu = '0;
    #1;
    checks++; if (bus_req !== 1'b0 || mem_stall !== 1'b0 || mmo !== 32'h0) begin errors++;
      $display("FAIL midbusy_async: got req=%b stall=%b mmo=%h expected 0 0 0", bus_req, mem_stall, mmo); end
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    checks++; if (bus_err !== 1'b0 || led_out !== 10'h0 || mmo !== 32'h0) begin errors++;
      $display("FAIL after_reset: got err=%b led=%h mmo=%h expected 0 000 0", bus_err, led_out, mmo); end
    @(posedge clock); #1;
    exp_q.push_back(32'h0BAD_CAFE);
    run_mem(1'b0, 32'h700, 32'h0, 1, 32'h0BAD_CAFE, r_stall, r_busy, r_mmo, r_addr, r_wdata, r_we, r_held);
    exp_v = exp_q.pop_front();
    checks++; if (r_stall != 2 || r_mmo !== exp_v) begin errors++;
      $display("FAIL post_reset_load: got stall=%0d mmo=%h expected 2 %h", r_stall, r_mmo, exp_v); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_io();
    test_timeout();
    test_ack_idle();
    test_back_to_back();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
